// File: rtl/book_feed_arbiter.sv
// rtl/book_feed_arbiter.sv - round-robin arbiter sharing the order_book market-data write port
// Optional feature macro BOOK_FEED_BURST_LOCK_EN: a winner keeps priority for up to BURST_MAX grants.
module book_feed_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_W     = 32,
    parameter int GAP_CYCLES = 1,
    parameter int BURST_MAX  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SRC*DATA_W-1:0]     src_data,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic                          book_hold,
    output logic [DATA_W-1:0]             md_data,
    output logic                          md_valid,
    output logic [$clog2(NUM_SRC)-1:0]    md_src,
    output logic [15:0]                   xfer_count
);

    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    if (NUM_SRC < 2 || NUM_SRC > 8 || BURST_MAX < 1) begin : g_bad_param
        $error("book_feed_arbiter: NUM_SRC must be 2..8 and BURST_MAX at least 1");
    end

    typedef enum logic {
        ST_ARB,
        ST_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [DATA_W-1:0]   md_data_q, md_data_d;
    logic                md_valid_q, md_valid_d;
    logic [SRC_W-1:0]    md_src_q, md_src_d;
    logic [15:0]         xfer_count_q, xfer_count_d;
    logic [SRC_W-1:0]    win_idx;
    logic                win_found;
    logic                xfer;

`ifdef BOOK_FEED_BURST_LOCK_EN
    localparam int BURST_W = $clog2(BURST_MAX + 1);
    logic [BURST_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [BURST_W-1:0]  base_cnt;
`endif

    function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] i);
        if (int'(i) == NUM_SRC - 1) return '0;
        return i + 1'b1;
    endfunction

    // Scan from the far end back towards rr_ptr so the last hit is the highest-priority requester.
    always_comb begin : p_winner
        int cand;
        win_idx   = '0;
        win_found = 1'b0;
        cand      = 0;
        for (int off = NUM_SRC - 1; off >= 0; off--) begin
            cand = (int'(rr_ptr_q) + off) % NUM_SRC;
            if (src_valid[cand[SRC_W-1:0]]) begin
                win_idx   = cand[SRC_W-1:0];
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        src_ready = '0;
        if (!reset && state_q == ST_ARB && win_found && !book_hold) begin
            src_ready[win_idx] = 1'b1;
        end
    end

    assign xfer = (src_ready & src_valid) != '0;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gap_cnt_d    = gap_cnt_q;
        md_data_d    = md_data_q;
        md_valid_d   = 1'b0;
        md_src_d     = md_src_q;
        xfer_count_d = xfer_count_q;
`ifdef BOOK_FEED_BURST_LOCK_EN
        burst_cnt_d  = burst_cnt_q;
        base_cnt     = (win_idx == rr_ptr_q) ? burst_cnt_q : '0;
`endif
        case (state_q)
            ST_ARB: begin
                if (xfer) begin
                    md_valid_d   = 1'b1;
                    md_data_d    = src_data[win_idx*DATA_W +: DATA_W];
                    md_src_d     = win_idx;
                    xfer_count_d = xfer_count_q + 16'd1;
`ifdef BOOK_FEED_BURST_LOCK_EN
                    if (int'(base_cnt) + 1 >= BURST_MAX) begin
                        rr_ptr_d    = next_idx(win_idx);
                        burst_cnt_d = '0;
                    end else begin
                        rr_ptr_d    = win_idx;
                        burst_cnt_d = base_cnt + 1'b1;
                    end
`else
                    rr_ptr_d     = next_idx(win_idx);
`endif
                    if (GAP_CYCLES > 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_W'(GAP_CYCLES);
                    end
                end
`ifdef BOOK_FEED_BURST_LOCK_EN
                // A locked owner that has gone idle gives up its priority.
                else if (burst_cnt_q != '0 && !src_valid[rr_ptr_q]) begin
                    rr_ptr_d    = next_idx(rr_ptr_q);
                    burst_cnt_d = '0;
                end
`endif
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q - 1'b1;
                if (gap_cnt_q <= GAP_W'(1)) begin
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_ARB;
            rr_ptr_q     <= '0;
            gap_cnt_q    <= '0;
            md_data_q    <= '0;
            md_valid_q   <= 1'b0;
            md_src_q     <= '0;
            xfer_count_q <= '0;
`ifdef BOOK_FEED_BURST_LOCK_EN
            burst_cnt_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gap_cnt_q    <= gap_cnt_d;
            md_data_q    <= md_data_d;
            md_valid_q   <= md_valid_d;
            md_src_q     <= md_src_d;
            xfer_count_q <= xfer_count_d;
`ifdef BOOK_FEED_BURST_LOCK_EN
            burst_cnt_q  <= burst_cnt_d;
`endif
        end
    end

    assign md_data    = md_data_q;
    assign md_valid   = md_valid_q;
    assign md_src     = md_src_q;
    assign xfer_count = xfer_count_q;

endmodule

// File: doc/book_feed_arbiter.md
Name: book_feed_arbiter

Overview:
- Shares the single order_book market-data write port (market_data_in / market_data_valid) between NUM_SRC independent feed requesters, e.g. multicast A/B lines, the DMA replay path and the host injection path.
- Each requester presents a valid/ready stream. The arbiter grants one source per write slot using round-robin priority.
- Inserts a programmable idle gap after every write so the book can recompute best_bid/best_ask before the next update.
- Sits between the streaming_interface/DMA front ends and order_book.

Parameters:
- NUM_SRC, 4: number of requesters; legal range 2..8.
- DATA_W, 32: width of one market-data word.
- GAP_CYCLES, 1: idle cycles forced after each write; 0 allows back-to-back writes.
- BURST_MAX, 4: maximum consecutive grants to one source; used only with BURST_LOCK_EN.

Ports:
- clk, input, 1: single clock; all logic on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- src_data, input, NUM_SRC*DATA_W: source i occupies bits [i*DATA_W +: DATA_W].
- src_valid, input, NUM_SRC: per-source request/valid.
- src_ready, output, NUM_SRC: per-source accept; combinational; at most one bit high.
- book_hold, input, 1: back-pressure from the book/host; blocks new grants while high.
- md_data, output, DATA_W: registered word to order_book market_data_in.
- md_valid, output, 1: registered one-cycle strobe to order_book market_data_valid.
- md_src, output, $clog2(NUM_SRC): index of the source that produced md_data.
- xfer_count, output, 16: total accepted words; wraps at 16'hFFFF -> 0.

Behaviour:
Reset (asynchronous, effective immediately, independent of clk):
- md_data = 0, md_valid = 0, md_src = 0, xfer_count = 0.
- Round-robin pointer rr_ptr = 0, gap counter = 0, burst counter = 0, state = ARB.
- src_ready = 0 while reset is high.
- Reset asserted mid-transfer aborts it: no md_valid is produced for that word and the source must re-present it.

State ARB:
- Winner is the first i with src_valid[i] = 1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
- src_ready[winner] = 1 only if book_hold = 0. All other src_ready bits are 0.
- A transfer occurs when src_valid[w] & src_ready[w] in that cycle.

On a transfer:
- Next edge: md_data <= src word, md_src <= w, md_valid <= 1, xfer_count <= xfer_count + 1 (mod 2^16).
- rr_ptr <= (w + 1) mod NUM_SRC, unless overridden by burst lock.
- If GAP_CYCLES > 0, go to GAP with the gap counter loaded to GAP_CYCLES. Otherwise stay in ARB, giving a back-to-back throughput of 1 word/cycle.

No transfer, including while book_hold = 1:
- md_valid <= 0, state and rr_ptr unchanged.

State GAP:
- src_ready = 0 for all sources.
- md_valid <= 0 after the first cycle, so md_valid is exactly one cycle wide.
- Gap counter decrements every cycle regardless of book_hold. At count 1 -> ARB; the next grant is possible in the following cycle.

Timing and signal rules:
- Latency: source handshake to md_valid is 1 cycle.
- Minimum spacing of md_valid pulses is GAP_CYCLES + 1 cycles.
- md_data and md_src hold their last value while md_valid = 0.
- Sources must hold src_data stable while src_valid = 1 and not ready. The arbiter does not require src_valid to stay high; a source may withdraw before it is granted.
- No requests: state stays ARB, outputs idle, rr_ptr unchanged.
- book_hold asserted in the same cycle a winner exists: no transfer; the winner is re-evaluated next cycle, and a higher-priority newcomer may take the slot.
- All sources valid every cycle: grants rotate 0,1,2,3,0,... and no source waits more than NUM_SRC slots.
- xfer_count wraps silently; there is no saturation flag.

Optional Feature:
Macro: BOOK_FEED_BURST_LOCK_EN

Defined:
- After a transfer from source w, rr_ptr stays at w, so w keeps top priority on the next ARB slot. The burst counter increments on each transfer.
- When the burst counter reaches BURST_MAX, rr_ptr advances to w+1 and the counter clears.
- The counter also clears and rr_ptr advances if w is not valid when ARB is next evaluated.

Not defined:
- Strict round-robin after every transfer, as described above.
- No burst counter logic is present.

Test Plan:
1. Reset release, src_valid = 4'b0001, src word 32'h0000_1000, GAP_CYCLES = 1 -> src_ready[0] high in cycle 0; md_valid = 1 with md_data = 32'h0000_1000 and md_src = 0 in cycle 1; src_ready all 0 in cycle 1; xfer_count = 1.
2. All four sources valid continuously, GAP_CYCLES = 1, no burst lock -> md_src sequence 0,1,2,3,0,1 with md_valid every 2nd cycle; xfer_count = 6 after 12 cycles.
3. book_hold = 1 for 5 cycles with src_valid = 4'b0110, then released -> no src_ready and no md_valid during hold; source 1 granted on the first cycle after release, then source 2.
4. GAP_CYCLES = 0, source 2 valid for 8 cycles -> 8 back-to-back md_valid pulses; xfer_count = 8; md_data tracks the src word with 1-cycle latency.
5. reset pulsed for 1 cycle, asynchronously, between the handshake edge and md_valid, with xfer_count = 16'hFFFF preloaded by 65535 transfers -> all outputs 0 immediately; rr_ptr = 0; no md_valid for the aborted word. Separately: 65536 transfers without reset -> xfer_count wraps to 0.
6. With BOOK_FEED_BURST_LOCK_EN, BURST_MAX = 4, all sources valid -> md_src 0,0,0,0,1,1,1,1,2; without the macro -> 0,1,2.
